// File: rtl/pipeline_pkg.sv
// Shared pipeline types: hazard sequencer state and the per-stage control bundle.
// Also holds the canonical control words and the RUN-mode hazard resolution.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hazard_state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0
  };

  // Whole pipeline held; WB gets a bubble so the stalled MEM op does not retire twice.
  localparam stage_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1
  };

  localparam stage_ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b1
  };

  // Branch wins over load-use: the dependent instruction in ID is discarded anyway.
  function automatic stage_ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
    stage_ctrl_t c;
    c = CTRL_RUN;
    if (branch_taken) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_write    = 1'b0;
      c.if_id_write = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance monitors.
// Holds at all-ones once reached; cleared by synchronous active-low reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes, data-memory
// wait freezes with a timeout that halts the core, plus stall/flush counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hazard_state_e     r_state;
  hazard_state_e     w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  stage_ctrl_t       w_ctrl;
  logic              w_load_use;
  logic              w_miss;
  logic              w_stall_inc;
  logic              w_flush_inc;

  assign w_load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_ex_rd == id_rs1)) ||
                       (id_uses_rs2 && (id_ex_rd == id_rs2)));

  assign w_miss = mem_req && !dmem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_ctrl          = CTRL_RUN;
    if (!rst_n) begin
      w_ctrl = CTRL_RESET;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_miss) begin
            w_ctrl          = CTRL_FREEZE;
            w_state_next    = MEM_WAIT;
            w_wait_cnt_next = WAIT_W'(1);
          end else begin
            w_ctrl = run_ctrl(ex_branch_taken, w_load_use);
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            w_ctrl = CTRL_FREEZE;
            // The miss cycle in RUN counts as wait 1, so HALT follows MEM_TIMEOUT+1 frozen cycles.
            if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
              w_state_next = HALT;
            end else begin
              w_wait_cnt_next = r_wait_cnt + 1'b1;
            end
          end else begin
            w_ctrl          = run_ctrl(ex_branch_taken, w_load_use);
            w_state_next    = RUN;
            w_wait_cnt_next = '0;
          end
        end
        HALT: begin
          w_ctrl = CTRL_FREEZE;
        end
        default: begin
          w_ctrl       = CTRL_FREEZE;
          w_state_next = RUN;
        end
      endcase
    end
  end

  assign pc_write     = w_ctrl.pc_write;
  assign if_id_write  = w_ctrl.if_id_write;
  assign id_ex_write  = w_ctrl.id_ex_write;
  assign ex_mem_write = w_ctrl.ex_mem_write;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;
  assign halted       = rst_n && (r_state == HALT);

  assign w_stall_inc = !w_ctrl.pc_write && (r_state != HALT);
  assign w_flush_inc = w_ctrl.if_id_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );

endmodule
